// File: rtl/pwm_duty_ramp_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pwm_ramp_pkg
// Shared constants, types and the duty step helper for the PWM duty ramp
// sequencer slice.
//   NUM_CH / DUTY_W / TICK_W : channel count, duty width, interval width
//   ch_state_t               : per-channel ramp state (IDLE, WAIT)
//   ch_idx_t                 : 2-bit channel index
//   ramp_next()              : one clamped step of cur toward tgt
// ---------------------------------------------------------------------------
package pwm_ramp_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned DUTY_W = 8;
   localparam int unsigned TICK_W = 16;

   typedef enum logic {IDLE, WAIT} ch_state_t;

   typedef logic [1:0] ch_idx_t;

   // Move cur toward tgt by step using a 9-bit intermediate so the result
   // saturates at tgt instead of wrapping. A zero step jumps straight to tgt.
   function automatic logic [DUTY_W-1:0] ramp_next(input logic [DUTY_W-1:0] cur,
                                                   input logic [DUTY_W-1:0] tgt,
                                                   input logic [DUTY_W-1:0] step);
      logic [DUTY_W:0] sum;
      logic [DUTY_W:0] diff;
      sum       = {1'b0, cur} + {1'b0, step};
      diff      = {1'b0, cur} - {1'b0, step};
      ramp_next = tgt;
      if (step != '0) begin
         if (cur < tgt) begin
            if (sum < {1'b0, tgt}) ramp_next = sum[DUTY_W-1:0];
         end else if (cur > tgt) begin
            // diff[DUTY_W] is the borrow: cur - step went below zero
            if (!diff[DUTY_W] && (diff[DUTY_W-1:0] > tgt)) ramp_next = diff[DUTY_W-1:0];
         end
      end
   endfunction

endpackage

// File: rtl/pwm_duty_ramp_sequencer_if.sv
// ---------------------------------------------------------------------------
// pwm_duty_ramp_sequencer_if
// Ramp command channel from the SPI register file to the sequencer.
//   cmd_valid    : command present
//   cmd_ready    : command accepted when valid & ready
//   cmd_ch       : target channel (0=g0c0, 1=g0c1, 2=g1c0, 3=g1c1)
//   cmd_target   : final duty value
//   cmd_step     : duty change per update (0 = jump to target)
//   cmd_interval : cycles between updates (0 treated as 1)
// Modports: master (command source), slave (sequencer).
// ---------------------------------------------------------------------------
interface pwm_duty_ramp_sequencer_if;
   import pwm_ramp_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   ch_idx_t           cmd_ch;
   logic [DUTY_W-1:0] cmd_target;
   logic [DUTY_W-1:0] cmd_step;
   logic [TICK_W-1:0] cmd_interval;

   modport master (
      output cmd_valid, cmd_ch, cmd_target, cmd_step, cmd_interval,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_ch, cmd_target, cmd_step, cmd_interval,
      output cmd_ready
   );

endinterface

// File: rtl/pwm_duty_ramp_sequencer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// pwm_ramp_rr_arbiter
// Four-way round-robin arbiter for the shared duty step unit.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-channel update request
//   gnt      : one-hot grant (at most one bit set)
// Search starts at pointer+1; the pointer moves to the granted channel and
// holds when nothing is granted. Reset leaves the pointer at 3 so channel 0
// wins first.
// ---------------------------------------------------------------------------
module pwm_ramp_rr_arbiter
   import pwm_ramp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] gnt
);

   ch_idx_t ptr_q;
   ch_idx_t idx;
   ch_idx_t win_idx;
   logic    found;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         idx = ptr_q + ch_idx_t'(i);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            win_idx  = idx;
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= ch_idx_t'(NUM_CH - 1);
      end else if (found) begin
         ptr_q <= win_idx;
      end
   end

endmodule

// File: rtl/pwm_duty_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_duty_ramp_sequencer
// Ramps the four PWM duty registers toward commanded targets, one shared
// step unit time-shared by a round-robin arbiter.
//   clk, rst         : clock, synchronous active-high reset
//   cmd_if (slave)   : ramp command channel
//   duty_out         : packed duties, channel c at [8c+7:8c]
//   busy             : per-channel ramp in progress
//   done_pulse       : one-cycle pulse when a channel reaches its target
// Optional build macro PWM_RAMP_SYNC_EN adds pwm_period_start and drives
// duty_out from shadow registers refreshed on that pulse.
// ---------------------------------------------------------------------------
module pwm_duty_ramp_sequencer
   import pwm_ramp_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
`ifdef PWM_RAMP_SYNC_EN
   input  logic                     pwm_period_start,
`endif
   pwm_duty_ramp_sequencer_if.slave cmd_if,
   output logic [NUM_CH*DUTY_W-1:0] duty_out,
   output logic [NUM_CH-1:0]        busy,
   output logic [NUM_CH-1:0]        done_pulse
);

   ch_state_t         state_q  [NUM_CH];
   logic [DUTY_W-1:0] duty_q   [NUM_CH];
   logic [DUTY_W-1:0] tgt_q    [NUM_CH];
   logic [DUTY_W-1:0] step_q   [NUM_CH];
   logic [TICK_W-1:0] reload_q [NUM_CH];
   logic [TICK_W-1:0] cnt_q    [NUM_CH];

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] gnt;
   ch_idx_t           gnt_idx;
   logic [DUTY_W-1:0] step_next;
   logic              accept;
   logic [TICK_W-1:0] cmd_reload;

   assign cmd_if.cmd_ready = ~rst;
   assign accept           = cmd_if.cmd_valid & cmd_if.cmd_ready;
   assign cmd_reload       = (cmd_if.cmd_interval == '0) ? '0
                                                         : cmd_if.cmd_interval - TICK_W'(1);

   always_comb begin
      req  = '0;
      busy = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         req[c]  = (state_q[c] == WAIT) && (cnt_q[c] == '0);
         busy[c] = (state_q[c] == WAIT);
      end
   end

   pwm_ramp_rr_arbiter u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   always_comb begin
      gnt_idx = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (gnt[c]) gnt_idx = ch_idx_t'(c);
      end
   end

   assign step_next = ramp_next(duty_q[gnt_idx], tgt_q[gnt_idx], step_q[gnt_idx]);

   always_ff @(posedge clk) begin
      if (rst) begin
         done_pulse <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_q[c]  <= IDLE;
            duty_q[c]   <= '0;
            tgt_q[c]    <= '0;
            step_q[c]   <= '0;
            reload_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
      end else begin
         done_pulse <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            // A new command takes priority over a same-cycle grant; the step
            // result for that channel is dropped.
            if (accept && (cmd_if.cmd_ch == ch_idx_t'(c))) begin
               tgt_q[c]    <= cmd_if.cmd_target;
               step_q[c]   <= cmd_if.cmd_step;
               reload_q[c] <= cmd_reload;
               cnt_q[c]    <= cmd_reload;
               if (cmd_if.cmd_target == duty_q[c]) begin
                  state_q[c]    <= IDLE;
                  done_pulse[c] <= 1'b1;
               end else begin
                  state_q[c] <= WAIT;
               end
            end else if (gnt[c]) begin
               duty_q[c] <= step_next;
               if (step_next == tgt_q[c]) begin
                  state_q[c]    <= IDLE;
                  done_pulse[c] <= 1'b1;
               end else begin
                  cnt_q[c] <= reload_q[c];
               end
            end else if ((state_q[c] == WAIT) && (cnt_q[c] != '0)) begin
               cnt_q[c] <= cnt_q[c] - TICK_W'(1);
            end
         end
      end
   end

`ifdef PWM_RAMP_SYNC_EN
   logic [DUTY_W-1:0] shadow_q [NUM_CH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) shadow_q[c] <= '0;
      end else if (pwm_period_start) begin
         for (int unsigned c = 0; c < NUM_CH; c++) shadow_q[c] <= duty_q[c];
      end
   end

   always_comb begin
      duty_out = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) duty_out[c*DUTY_W +: DUTY_W] = shadow_q[c];
   end
`else
   always_comb begin
      duty_out = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) duty_out[c*DUTY_W +: DUTY_W] = duty_q[c];
   end
`endif

endmodule

// File: tb/tb_pwm_duty_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_ramp_sequencer
// Directed scenarios with literal expectations, then randomized commands.
// A time-based reference model (absolute due cycles, round-robin pick) is
// compared with the DUT one time unit after every rising edge.
// ---------------------------------------------------------------------------
module tb_pwm_duty_ramp_sequencer;
   import pwm_ramp_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pwm_duty_ramp_sequencer_if cmd_if();
   logic [31:0] duty_out;
   logic [3:0]  busy;
   logic [3:0]  done_pulse;
`ifdef PWM_RAMP_SYNC_EN
   logic pwm_period_start = 1'b0;
`endif

   pwm_duty_ramp_sequencer dut (
      .clk              (clk),
      .rst              (rst),
`ifdef PWM_RAMP_SYNC_EN
      .pwm_period_start (pwm_period_start),
`endif
      .cmd_if           (cmd_if.slave),
      .duty_out         (duty_out),
      .busy             (busy),
      .done_pulse       (done_pulse)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_duty[4], m_shadow[4], m_tgt[4], m_step[4], m_ivl[4], m_due[4];
   bit m_busy[4], m_done[4];
   int m_ptr = 3;
   int cyc = 0;
   bit seen_rst = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, got, got, exp, exp);
      end
   endtask

   function automatic int model_next(input int cur, input int tgt, input int step);
      if (step == 0) return tgt;
      if (cur < tgt) return (cur + step > tgt) ? tgt : cur + step;
      if (cur > tgt) return (cur - step < tgt) ? tgt : cur - step;
      return tgt;
   endfunction

   // model update on each edge, then compare all outputs
   always @(posedge clk) begin : model_and_compare
      int g, ch, n, c;
      logic [31:0] e_duty;
      logic [3:0]  e_busy, e_done;
      cyc++;
      if (rst) begin
         seen_rst = 1'b1;
         m_ptr = 3;
         for (int k = 0; k < 4; k++) begin
            m_duty[k] = 0; m_shadow[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_due[k] = 0;
         end
      end else begin
         g = -1;
         for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (g < 0 && m_busy[c] && m_due[c] <= cyc) g = c;
         end
`ifdef PWM_RAMP_SYNC_EN
         if (pwm_period_start) for (int k = 0; k < 4; k++) m_shadow[k] = m_duty[k];
`endif
         for (int k = 0; k < 4; k++) m_done[k] = 0;
         ch = int'(cmd_if.cmd_ch);
         if (g >= 0) begin
            m_ptr = g;
            if (!(cmd_if.cmd_valid && ch == g)) begin
               n = model_next(m_duty[g], m_tgt[g], m_step[g]);
               m_duty[g] = n;
               if (n == m_tgt[g]) begin
                  m_busy[g] = 0; m_done[g] = 1;
               end else begin
                  m_due[g] = cyc + m_ivl[g];
               end
            end
         end
         if (cmd_if.cmd_valid) begin
            m_tgt[ch]  = int'(cmd_if.cmd_target);
            m_step[ch] = int'(cmd_if.cmd_step);
            m_ivl[ch]  = (cmd_if.cmd_interval == 0) ? 1 : int'(cmd_if.cmd_interval);
            m_due[ch]  = cyc + m_ivl[ch];
            if (m_tgt[ch] == m_duty[ch]) begin
               m_busy[ch] = 0; m_done[ch] = 1;
            end else begin
               m_busy[ch] = 1;
            end
         end
      end
      #1;
      if (seen_rst) begin
         e_duty = '0; e_busy = '0; e_done = '0;
         for (int k = 0; k < 4; k++) begin
`ifdef PWM_RAMP_SYNC_EN
            e_duty[k*8 +: 8] = m_shadow[k][7:0];
`else
            e_duty[k*8 +: 8] = m_duty[k][7:0];
`endif
            e_busy[k] = m_busy[k];
            e_done[k] = m_done[k];
         end
         check("duty_out", duty_out, e_duty);
         check("busy", {28'b0, busy}, {28'b0, e_busy});
         check("done_pulse", {28'b0, done_pulse}, {28'b0, e_done});
         check("cmd_ready", {31'b0, cmd_if.cmd_ready}, {31'b0, ~rst});
      end
   end

   // working duty of channel c as visible for literal checks
   function automatic logic [31:0] dduty(input int c);
`ifdef PWM_RAMP_SYNC_EN
      return m_duty[c];
`else
      return {24'b0, duty_out[c*8 +: 8]};
`endif
   endfunction

   task automatic send(input int ch, input int tgt, input int step, input int ivl);
      @(negedge clk);
      cmd_if.cmd_ch       = ch_idx_t'(ch);
      cmd_if.cmd_target   = 8'(tgt);
      cmd_if.cmd_step     = 8'(step);
      cmd_if.cmd_interval = 16'(ivl);
      cmd_if.cmd_valid    = 1'b1;
      @(negedge clk);
      cmd_if.cmd_valid    = 1'b0;
   endtask

   task automatic after(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      int r;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_ch = '0;
      cmd_if.cmd_target = '0;
      cmd_if.cmd_step = '0;
      cmd_if.cmd_interval = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // single ramp ch0: 0 -> 100, step 25, interval 4
      send(0, 100, 25, 4);
      for (int i = 1; i <= 4; i++) begin
         after(4);
         check("ramp_ch0_duty", dduty(0), 25 * i);
      end
      check("ramp_ch0_done", {31'b0, done_pulse[0]}, 1);
      check("ramp_ch0_busy", {31'b0, busy[0]}, 0);

      // reset while ch2 is mid-ramp at 40
      send(2, 200, 10, 1);
      after(4);
      check("pre_reset_ch2", dduty(2), 40);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("reset_duty", duty_out, 0);
      check("reset_busy", {28'b0, busy}, 0);
      check("reset_done", {28'b0, done_pulse}, 0);
      after(5);
      check("post_reset_ch2", dduty(2), 0);
      check("post_reset_busy", {28'b0, busy}, 0);

`ifdef PWM_RAMP_SYNC_EN
      // working duty changes mid-period; output holds until period start
      send(0, 77, 0, 1);
      after(1);
      check("sync_hold", {24'b0, duty_out[7:0]}, 0);
      @(negedge clk); pwm_period_start = 1'b1;
      @(negedge clk); pwm_period_start = 1'b0;
      check("sync_copy", {24'b0, duty_out[7:0]}, 77);
      send(0, 0, 0, 1);
      after(2);
`endif

      // contention: all channels step 1 toward 3 at interval 1
      for (int c = 0; c < 4; c++) send(c, 3, 1, 1);
      after(24);
      for (int c = 0; c < 4; c++) check("contend_final", dduty(c), 3);
      check("contend_busy", {28'b0, busy}, 0);

      // clamping on ch1
      send(1, 250, 0, 1);
      after(1);
      check("ch1_jump_250", dduty(1), 250);
      send(1, 255, 10, 1);
      after(1);
      check("ch1_clamp_255", dduty(1), 255);
      check("ch1_done_255", {31'b0, done_pulse[1]}, 1);
      send(1, 5, 0, 1);
      after(1);
      check("ch1_jump_5", dduty(1), 5);
      send(1, 0, 10, 1);
      after(1);
      check("ch1_clamp_0", dduty(1), 0);
      check("ch1_done_0", {31'b0, done_pulse[1]}, 1);

      // ch2: full-scale step, then target equal to current
      send(2, 0, 0, 1);
      after(1);
      send(2, 255, 255, 2);
      after(1);
      check("ch2_latency", dduty(2), 0);
      after(1);
      check("ch2_full_step", dduty(2), 255);
      send(2, 255, 7, 3);
      check("ch2_same_done", {31'b0, done_pulse[2]}, 1);
      check("ch2_same_busy", {31'b0, busy[2]}, 0);
      check("ch2_same_duty", dduty(2), 255);

      // ch3 override mid-ramp
      send(3, 0, 0, 1);
      after(1);
      send(3, 200, 10, 1);
      after(12);
      check("ch3_mid", dduty(3), 120);
      send(3, 50, 10, 1);
      after(7);
      check("ch3_override", dduty(3), 50);
      check("ch3_done", {31'b0, done_pulse[3]}, 1);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 599) == 0);
         cmd_if.cmd_valid  = ($urandom_range(0, 2) == 0);
         cmd_if.cmd_ch     = ch_idx_t'($urandom_range(0, 3));
         cmd_if.cmd_target = 8'($urandom_range(0, 255));
         r = $urandom_range(0, 9);
         cmd_if.cmd_step   = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 40));
         r = $urandom_range(0, 9);
         cmd_if.cmd_interval = (r == 0) ? 16'd20 : 16'($urandom_range(0, 4));
`ifdef PWM_RAMP_SYNC_EN
         pwm_period_start = ($urandom_range(0, 7) == 0);
`endif
      end
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
